bn_layer_pipelined: RTL and testbench
=====================================

Name: bn_layer_pipelined

Overview:
Next-generation batch-normalization layer.
- Applies a folded per-channel affine transform y = sat(((x * scale) >>> FRAC_BITS) + offset) to LANES channels per beat.
- Uses a 2-stage valid-ready pipeline with saturation and a frame-boundary flag.
- Sits between a conv/dense layer and its activation. Mean and variance are pre-folded offline into the scale/offset tables.

Parameters:
INPUT_SIZE, 8, channels per frame; must be a multiple of LANES
WORD_SIZE, 16, signed fixed-point width of data and coefficients
FRAC_BITS, 8, fractional bits of scale; must be in 1..WORD_SIZE-1
LANES, 1, channels processed per beat
MEM_INIT_SCALE, "bn_scale.mif", ROM init for scale; one LANES*WORD_SIZE word per group
MEM_INIT_OFFSET, "bn_offset.mif", ROM init for offset; same layout, already at output scale

Ports:
clk_i  input  1  clock
reset_i  input  1  asynchronous, active-high reset
ready_o  output  1  this layer can accept a beat
valid_i  input  1  upstream beat valid
data_r_i  input  LANES*WORD_SIZE  signed lanes; lane k in bits [k*WORD_SIZE +: WORD_SIZE]
valid_o  output  1  output beat valid
ready_i  input  1  downstream accepts
data_r_o  output  LANES*WORD_SIZE  normalized lanes, driven directly from a register
last_o  output  1  qualifies valid_o; high on the final group of a frame

Behaviour:
- Reset: asynchronous on reset_i high. While asserted, ready_o=0, valid_o=0, last_o=0, data_r_o=0. The group counter clears and both pipeline stages empty. Reset mid-frame discards all in-flight beats; the next accepted beat uses group 0.
- Groups: NUM_GROUPS = INPUT_SIZE/LANES. The group counter increments on each accepted input (valid_i && ready_o) and wraps from NUM_GROUPS-1 to 0. Beat n of the stream uses coefficient group n mod NUM_GROUPS.
- ROMs: synchronous read, addressed by the counter's next value so coefficients align with the accepted beat. There is no bubble between consecutive beats.
- Stage 1 (S1): registers the full-precision product x*scale (2*WORD_SIZE signed) per lane, the offset, and the last flag.
- Stage 2 (S2):
  - arithmetic shift right by FRAC_BITS;
  - sign-extended add of offset in 2*WORD_SIZE+1 bits;
  - saturate to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1];
  - register into data_r_o.
- Lanes are fully independent.
- Handshake:
  - Each stage holds valid_r. A stage loads when it is empty or its contents move on in the same cycle.
  - S2 moves on when valid_o && ready_i.
  - ready_o = !s1_valid || s1_advance, which is combinational through ready_i. Full throughput is one beat per cycle.
- Latency: the accepted beat appears on valid_o 2 cycles later when there is no backpressure.
- Backpressure: with ready_i low, data_r_o and last_o hold stable while valid_o is high. The pipeline absorbs 2 beats, then ready_o drops. No beat is lost or duplicated.
- Simultaneous accept and emit in both stages is a pass-through with no stall.
- last_o = 1 exactly on the output beat that used group NUM_GROUPS-1.
- valid_i may drop mid-frame; the counter holds its position.

Optional Feature:
- BN_ROUND_EN defined: add 2^(FRAC_BITS-1) to the product before the shift, giving round-half-up.
- BN_ROUND_EN undefined: plain truncation toward negative infinity (arithmetic shift).
- Latency and handshake are identical in both builds.

Decomposition:
- Package bn_pkg holds:
  - function bn_sat(wide value, WORD_SIZE) -> saturated word;
  - localparam helper for the group counter width, $clog2 with minimum 1;
  - state typedef for stage valid (eEMPTY/eFULL).
- Sub-module bn_lane: a single lane's multiply/shift/add/saturate datapath, instantiated LANES times in a generate loop.
- The existing ROM module is reused for the coefficient tables.

Test Plan (WORD_SIZE=16, FRAC_BITS=8, INPUT_SIZE=4, LANES=1 unless stated):
1. Basic math: scale=0x0100, offset=0x0080, x=0x0200 -> data_r_o=0x0280, valid_o exactly 2 cycles after acceptance.
2. Saturation and sign:
   - x=0x7FFF, scale=0x0200 -> 0x7FFF.
   - x=0x8000, scale=0x0200 -> 0x8000.
   - x=0xFF00, scale=0x0200, offset=0 -> 0xFE00.
3. Wrap and last: stream 8 back-to-back beats with scales {1,2,3,4}.0 -> coefficient index sequence 0,1,2,3,0,1,2,3; last_o on output beats 4 and 8; 8 outputs in 8 consecutive cycles.
4. Backpressure: continuous valid_i, ready_i low for 5 cycles -> ready_o low after 2 accepts; data_r_o stable while stalled; output order and values match the reference model.
5. Reset mid-frame: reset_i pulsed after group 1 is accepted -> valid_o drops immediately (asynchronous); the next beat uses group 0; no stale output appears.
6. LANES=2, INPUT_SIZE=4: lane values {0x0100,0xFF00} with scales {0x0200,0x0080} -> outputs {0x0200,0xFF80}; last_o on every second beat. Rounding build with x=0x0001, scale=0x0080 -> 0x0001 (truncated build -> 0x0000).

Source files
------------

// File: rtl/bn_pkg.sv
// Shared types and helpers for the batch-norm layer: stage occupancy state,
// group counter width and output saturation.
package bn_pkg;

  localparam int BN_WIDE_W = 64;

  typedef enum logic {
    eEMPTY = 1'b0,
    eFULL  = 1'b1
  } bn_stage_e;

  // Counter width for n groups; a single-group frame still needs one bit.
  function automatic int bn_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp a wide signed value into the signed range of word_size bits.
  function automatic logic signed [BN_WIDE_W-1:0] bn_sat(
    input logic signed [BN_WIDE_W-1:0] value,
    input int                          word_size
  );
    logic signed [BN_WIDE_W-1:0] hi;
    logic signed [BN_WIDE_W-1:0] lo;
    hi = (64'sd1 <<< (word_size - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/bn_lane.sv
// One lane of the batch-norm datapath: product register, then shift/offset/
// saturate into the output register. BN_ROUND_EN selects round-half-up.
module bn_lane
  import bn_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        s1_en_i,
  input  logic                        s2_en_i,
  input  logic signed [WORD_SIZE-1:0] x_i,
  input  logic signed [WORD_SIZE-1:0] scale_i,
  input  logic signed [WORD_SIZE-1:0] offset_i,
  output logic        [WORD_SIZE-1:0] y_o
);

  localparam int PW = 2 * WORD_SIZE;
  localparam int SW = PW + 1;

`ifdef BN_ROUND_EN
  localparam logic signed [SW-1:0] RND_HALF = SW'(1) <<< (FRAC_BITS - 1);
`endif

  logic signed [PW-1:0]        prod_q, prod_d;
  logic signed [WORD_SIZE-1:0] off_q, off_d;
  logic        [WORD_SIZE-1:0] y_q, y_d;
  logic signed [SW-1:0]        rnd_w, shifted_w, sum_w;
  logic signed [BN_WIDE_W-1:0] sat_w;
  logic                        unused_sat_hi;

  always_comb begin
    prod_d = prod_q;
    off_d  = off_q;
    y_d    = y_q;
    if (s1_en_i) begin
      prod_d = PW'(x_i) * PW'(scale_i);
      off_d  = offset_i;
    end
`ifdef BN_ROUND_EN
    rnd_w = SW'(prod_q) + RND_HALF;
`else
    rnd_w = SW'(prod_q);
`endif
    shifted_w = rnd_w >>> FRAC_BITS;
    sum_w     = shifted_w + SW'(off_q);
    sat_w     = bn_sat(BN_WIDE_W'(sum_w), WORD_SIZE);
    if (s2_en_i) y_d = sat_w[WORD_SIZE-1:0];
  end

  // Above WORD_SIZE the saturated value only carries sign copies.
  assign unused_sat_hi = ^sat_w[BN_WIDE_W-1:WORD_SIZE];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod_q <= '0;
      off_q  <= '0;
      y_q    <= '0;
    end else begin
      prod_q <= prod_d;
      off_q  <= off_d;
      y_q    <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/bn_rom.sv
// Synchronous-read coefficient table. Contents are an elaborated constant, so
// the table needs no load step; the output resets to entry 0.
module bn_rom #(
  parameter int                     WIDTH = 16,
  parameter int                     DEPTH = 8,
  parameter int                     AW    = 3,
  parameter logic [DEPTH*WIDTH-1:0] INIT  = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [AW-1:0]    addr_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = '0;
    if (int'(addr_i) < DEPTH) data_d = INIT[addr_i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) data_q <= INIT[WIDTH-1:0];
    else       data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/bn_layer_pipelined.sv
// Two-stage valid/ready batch-norm layer with per-group scale/offset tables
// and a frame-end flag. Build with BN_ROUND_EN for round-half-up.
module bn_layer_pipelined
  import bn_pkg::*;
#(
  parameter int INPUT_SIZE = 8,
  parameter int WORD_SIZE  = 16,
  parameter int FRAC_BITS  = 8,
  parameter int LANES      = 1,
  parameter logic [INPUT_SIZE*WORD_SIZE-1:0] MEM_INIT_SCALE =
    {INPUT_SIZE{WORD_SIZE'(1 << FRAC_BITS)}},
  parameter logic [INPUT_SIZE*WORD_SIZE-1:0] MEM_INIT_OFFSET = '0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  output logic                       ready_o,
  input  logic                       valid_i,
  input  logic [LANES*WORD_SIZE-1:0] data_r_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [LANES*WORD_SIZE-1:0] data_r_o,
  output logic                       last_o
);

  localparam int NUM_GROUPS = INPUT_SIZE / LANES;
  localparam int CNT_W      = bn_cnt_w(NUM_GROUPS);
  localparam int DW         = LANES * WORD_SIZE;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NUM_GROUPS - 1);

  bn_stage_e        s1_state_q, s1_state_d;
  bn_stage_e        s2_state_q, s2_state_d;
  logic             s1_last_q, s1_last_d;
  logic             s2_last_q, s2_last_d;
  logic [CNT_W-1:0] grp_q, grp_d;
  logic             accept, s1_advance, s2_advance, s2_load;
  logic [DW-1:0]    scale_w, offset_w;

  assign s2_advance = (s2_state_q == eFULL) && ready_i;
  assign s2_load    = (s2_state_q == eEMPTY) || s2_advance;
  assign s1_advance = (s1_state_q == eFULL) && s2_load;
  assign ready_o    = !reset_i && ((s1_state_q == eEMPTY) || s1_advance);
  assign accept     = valid_i && ready_o;

  always_comb begin
    s1_state_d = s1_state_q;
    s2_state_d = s2_state_q;
    s1_last_d  = s1_last_q;
    s2_last_d  = s2_last_q;
    grp_d      = grp_q;
    if (accept) begin
      s1_state_d = eFULL;
      s1_last_d  = (grp_q == LAST_GRP);
      grp_d      = (grp_q == LAST_GRP) ? '0 : grp_q + 1'b1;
    end else if (s1_advance) begin
      s1_state_d = eEMPTY;
    end
    if (s1_advance) begin
      s2_state_d = eFULL;
      s2_last_d  = s1_last_q;
    end else if (s2_advance) begin
      s2_state_d = eEMPTY;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_state_q <= eEMPTY;
      s2_state_q <= eEMPTY;
      s1_last_q  <= 1'b0;
      s2_last_q  <= 1'b0;
      grp_q      <= '0;
    end else begin
      s1_state_q <= s1_state_d;
      s2_state_q <= s2_state_d;
      s1_last_q  <= s1_last_d;
      s2_last_q  <= s2_last_d;
      grp_q      <= grp_d;
    end
  end

  // Tables are read at the counter's next value so the coefficients for the
  // next beat are already registered when that beat is presented.
  bn_rom #(.WIDTH(DW), .DEPTH(NUM_GROUPS), .AW(CNT_W), .INIT(MEM_INIT_SCALE)) u_rom_scale (
    .clk_i  (clk_i),
    .rst_i  (reset_i),
    .addr_i (grp_d),
    .data_o (scale_w)
  );

  bn_rom #(.WIDTH(DW), .DEPTH(NUM_GROUPS), .AW(CNT_W), .INIT(MEM_INIT_OFFSET)) u_rom_offset (
    .clk_i  (clk_i),
    .rst_i  (reset_i),
    .addr_i (grp_d),
    .data_o (offset_w)
  );

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bn_lane #(.WORD_SIZE(WORD_SIZE), .FRAC_BITS(FRAC_BITS)) u_lane (
      .clk_i    (clk_i),
      .rst_i    (reset_i),
      .s1_en_i  (accept),
      .s2_en_i  (s1_advance),
      .x_i      (data_r_i[k*WORD_SIZE +: WORD_SIZE]),
      .scale_i  (scale_w[k*WORD_SIZE +: WORD_SIZE]),
      .offset_i (offset_w[k*WORD_SIZE +: WORD_SIZE]),
      .y_o      (data_r_o[k*WORD_SIZE +: WORD_SIZE])
    );
  end

  assign valid_o = (s2_state_q == eFULL);
  assign last_o  = s2_last_q && valid_o;

endmodule

// File: tb/tb_bn_layer_pipelined.sv
// Directed bench: single-lane instance (groups scaled 1.0..4.0) and a
// two-lane instance; expected values are hand-computed.
module tb_bn_layer_pipelined;

`ifdef BN_ROUND_EN
  localparam logic [15:0] RND_Y = 16'h0001;
`else
  localparam logic [15:0] RND_Y = 16'h0000;
`endif

  logic        clk, rst;
  logic        a_ready_o, a_valid_i, a_valid_o, a_ready_i, a_last_o;
  logic [15:0] a_data_i, a_data_o;
  logic        b_ready_o, b_valid_i, b_valid_o, b_ready_i, b_last_o;
  logic [31:0] b_data_i, b_data_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] x_v[16];
  logic [31:0] exp_v[16];
  logic        last_v[16];

  bn_layer_pipelined #(
    .INPUT_SIZE(4), .WORD_SIZE(16), .FRAC_BITS(8), .LANES(1),
    .MEM_INIT_SCALE (64'h0400_0300_0200_0100),
    .MEM_INIT_OFFSET(64'hFF00_0010_0000_0080)
  ) dut_a (
    .clk_i(clk), .reset_i(rst), .ready_o(a_ready_o), .valid_i(a_valid_i),
    .data_r_i(a_data_i), .valid_o(a_valid_o), .ready_i(a_ready_i),
    .data_r_o(a_data_o), .last_o(a_last_o)
  );

  bn_layer_pipelined #(
    .INPUT_SIZE(4), .WORD_SIZE(16), .FRAC_BITS(8), .LANES(2),
    .MEM_INIT_SCALE (64'h0080_0200_0080_0200),
    .MEM_INIT_OFFSET(64'h0)
  ) dut_b (
    .clk_i(clk), .reset_i(rst), .ready_o(b_ready_o), .valid_i(b_valid_i),
    .data_r_i(b_data_i), .valid_o(b_valid_o), .ready_i(b_ready_i),
    .data_r_o(b_data_o), .last_o(b_last_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] x, input logic [31:0] e, input logic l);
    x_v[i] = x; exp_v[i] = e; last_v[i] = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid_i = 1'b0; a_ready_i = 1'b1;
    b_valid_i = 1'b0; b_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("rst_a_ready", a_ready_o, 0); chk("rst_a_valid", a_valid_o, 0);
    chk("rst_a_last", a_last_o, 0);   chk("rst_a_data", a_data_o, 0);
    chk("rst_b_ready", b_ready_o, 0); chk("rst_b_data", b_data_o, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Starts and ends just after a rising edge; ready_i is low for cycles
  // [st_lo, st_lo+st_len) counted from the first driven cycle.
  task automatic run_stream(input bit sel, input int n, input int st_lo, input int st_len,
                            input bit chk_lat);
    int sent, got, cyc, acc0, emit0, emit_last, st_acc, idx;
    logic rdy, vo, lo, ro, held_ok;
    logic [31:0] dout, held;
    sent = 0; got = 0; cyc = 0; st_acc = 0; held_ok = 0; held = '0;
    acc0 = -1; emit0 = -1; emit_last = -1;
    while (got < n && cyc < 100) begin
      rdy = !(cyc >= st_lo && cyc < st_lo + st_len);
      idx = (sent < n) ? sent : 0;
      if (sel) begin
        b_ready_i = rdy; b_valid_i = (sent < n); b_data_i = x_v[idx];
      end else begin
        a_ready_i = rdy; a_valid_i = (sent < n); a_data_i = x_v[idx][15:0];
      end
      @(negedge clk);
      vo   = sel ? b_valid_o : a_valid_o;
      lo   = sel ? b_last_o  : a_last_o;
      ro   = sel ? b_ready_o : a_ready_o;
      dout = sel ? b_data_o  : {16'h0, a_data_o};
      if (vo && rdy) begin
        chk("data", dout, exp_v[got]);
        chk("last", lo, last_v[got]);
        if (emit0 < 0) emit0 = cyc;
        emit_last = cyc;
        got++;
      end
      if (!rdy) begin
        if (vo) begin
          if (held_ok) chk("stall_hold", dout, held);
          else begin held = dout; held_ok = 1'b1; end
        end
        if (ro && sent < n) st_acc++;
        if (cyc == st_lo + st_len - 1) begin
          chk("stall_acc", st_acc, 2);
          chk("stall_rdy", ro, 0);
        end
      end
      if (sent < n && ro) begin
        if (sent == 0) acc0 = cyc;
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    a_valid_i = 1'b0; a_ready_i = 1'b1;
    b_valid_i = 1'b0; b_ready_i = 1'b1;
    chk("out_count", got, n);
    if (chk_lat) begin
      chk("latency", emit0 - acc0, 2);
      chk("burst", emit_last - emit0, n - 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_valid_i = 1'b0; a_ready_i = 1'b1; a_data_i = '0;
    b_valid_i = 1'b0; b_ready_i = 1'b1; b_data_i = '0;

    // Basic math, saturation, sign, offset-driven clamp
    do_reset();
    set_vec(0, 32'h0200, 32'h0280, 0); set_vec(1, 32'h7FFF, 32'h7FFF, 0);
    set_vec(2, 32'h0000, 32'h0010, 0); set_vec(3, 32'h3000, 32'h7FFF, 1);
    set_vec(4, 32'h0000, 32'h0080, 0); set_vec(5, 32'h8000, 32'h8000, 0);
    set_vec(6, 32'h0000, 32'h0010, 0); set_vec(7, 32'h2000, 32'h7F00, 1);
    set_vec(8, 32'h0000, 32'h0080, 0); set_vec(9, 32'hFF00, 32'hFE00, 0);
    run_stream(0, 10, 1000, 0, 1);

    // Wrap and last over two frames
    do_reset();
    set_vec(0, 32'h0010, 32'h0090, 0); set_vec(1, 32'h0010, 32'h0020, 0);
    set_vec(2, 32'h0010, 32'h0040, 0); set_vec(3, 32'h0010, 32'hFF40, 1);
    set_vec(4, 32'h0100, 32'h0180, 0); set_vec(5, 32'hFFF0, 32'hFFE0, 0);
    set_vec(6, 32'h0100, 32'h0310, 0); set_vec(7, 32'h0200, 32'h0700, 1);
    run_stream(0, 8, 1000, 0, 1);

    // Same stream with 5 cycles of backpressure from the start
    do_reset();
    run_stream(0, 8, 0, 5, 0);

    // Reset mid-frame
    do_reset();
    a_valid_i = 1'b1; a_data_i = 16'h0200;
    @(posedge clk); #1;
    a_data_i = 16'h0100;
    @(posedge clk); #1;
    a_valid_i = 1'b0;
    chk("mid_valid_pre", a_valid_o, 1);
    rst = 1'b1;
    #1;
    chk("mid_valid", a_valid_o, 0); chk("mid_data", a_data_o, 0);
    chk("mid_last", a_last_o, 0);   chk("mid_ready", a_ready_o, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale", a_valid_o, 0);
    end
    @(posedge clk); #1;
    set_vec(0, 32'h0100, 32'h0180, 0);
    run_stream(0, 1, 1000, 0, 1);

    // Two lanes, last every second beat, rounding on lane 1 of beat 2
    do_reset();
    set_vec(0, 32'hFF00_0100, 32'hFF80_0200, 0);
    set_vec(1, 32'h0001_0001, {RND_Y, 16'h0002}, 1);
    set_vec(2, 32'hFF00_0100, 32'hFF80_0200, 0);
    set_vec(3, 32'h0001_0001, {RND_Y, 16'h0002}, 1);
    run_stream(1, 4, 1000, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
